// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the digit-serial shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the magnitude helper handles; callers cast the result back down.
  localparam int unsigned MAG_W = 64;

  function automatic int unsigned num_steps(input int unsigned width_b,
                                            input int unsigned digit_bits);
    return (width_b + digit_bits - 1) / digit_bits;
  endfunction

  function automatic logic [MAG_W-1:0] magnitude(input logic [MAG_W-1:0] value,
                                                 input int unsigned     width,
                                                 input logic            is_signed);
    logic [MAG_W-1:0] mask;
    logic [MAG_W-1:0] field;
    logic [MAG_W-1:0] top;
    mask  = '1 >> (MAG_W - width);
    field = value & mask;
    top   = field >> (width - 1);
    if (is_signed && top[0]) begin
      field = (~field + MAG_W'(1)) & mask;
    end
    return field;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand / product handshake bundle for seq_multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH_A = 13,
  parameter int unsigned WIDTH_B = 4
);
  localparam int unsigned WIDTH_OUT = WIDTH_A + WIDTH_B;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH_A-1:0]   in_a;
  logic [WIDTH_B-1:0]   in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] out;
  logic                 busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out, busy
  );

endinterface

// File: rtl/seq_mult_digit_pp.sv
// Partial product of the shifted multiplicand and one multiplier digit.
module seq_mult_digit_pp #(
  parameter int unsigned WIDTH_OUT  = 17,
  parameter int unsigned DIGIT_BITS = 2
) (
  input  logic [WIDTH_OUT-1:0]  mag_a,
  input  logic [DIGIT_BITS-1:0] digit,
  output logic [WIDTH_OUT-1:0]  pp
);

  logic [DIGIT_BITS-1:0] d;

  always_comb begin
    pp = '0;
    d  = digit;
    for (int unsigned i = 0; i < DIGIT_BITS; i++) begin
      if (d[0]) begin
        pp = pp + (mag_a << i);
      end
      d = d >> 1;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Digit-serial shift-add multiplier, sign-magnitude internally, full-width product.
// Optional early termination on an exhausted multiplier: define SEQ_MULT_ZERO_SKIP_EN.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH_A    = 13,
  parameter int unsigned WIDTH_B    = 4,
  parameter int unsigned DIGIT_BITS = 2
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);

  localparam int unsigned WIDTH_OUT = WIDTH_A + WIDTH_B;
  localparam int unsigned NUM_STEPS = num_steps(WIDTH_B, DIGIT_BITS);
  localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH_OUT-1:0] mag_a;
  logic [WIDTH_B-1:0]   mag_b;
  logic                 neg;
  logic [WIDTH_OUT-1:0] acc;
  logic [STEP_W-1:0]    step;
  logic [WIDTH_OUT-1:0] out_r;

  logic [WIDTH_A-1:0]   cap_mag_a;
  logic [WIDTH_B-1:0]   cap_mag_b;
  logic                 cap_neg;
  logic [WIDTH_OUT-1:0] pp;
  logic [WIDTH_OUT-1:0] sum;
  logic [WIDTH_B-1:0]   mag_b_rem;
  logic                 in_ready_int;
  logic                 accept;
  logic                 last_step;
  logic                 finish_busy;
  logic                 skip_on_accept;

  // Magnitudes are unsigned at full operand width, so the most-negative value is exact.
  assign cap_mag_a = WIDTH_A'(magnitude(MAG_W'(bus.in_a), WIDTH_A, bus.in_signed));
  assign cap_mag_b = WIDTH_B'(magnitude(MAG_W'(bus.in_b), WIDTH_B, bus.in_signed));
  assign cap_neg   = bus.in_signed & (bus.in_a[WIDTH_A-1] ^ bus.in_b[WIDTH_B-1]);

  seq_mult_digit_pp #(
    .WIDTH_OUT  (WIDTH_OUT),
    .DIGIT_BITS (DIGIT_BITS)
  ) u_digit_pp (
    .mag_a (mag_a),
    .digit (mag_b[DIGIT_BITS-1:0]),
    .pp    (pp)
  );

  assign sum            = acc + pp;
  assign mag_b_rem      = mag_b >> DIGIT_BITS;
  assign last_step      = (step == STEP_W'(NUM_STEPS - 1));
  assign finish_busy    = last_step || (ZERO_SKIP && (mag_b_rem == '0));
  assign skip_on_accept = ZERO_SKIP && (cap_mag_b == '0);
  assign accept         = bus.in_valid && in_ready_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = skip_on_accept ? DONE : BUSY;
      BUSY: if (finish_busy) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_int  = (state == IDLE) && !rst;
    bus.in_ready  = in_ready_int;
    bus.out_valid = (state == DONE);
    bus.busy      = (state == BUSY) || (state == DONE);
    bus.out       = out_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      step  <= '0;
      out_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mag_a <= WIDTH_OUT'(cap_mag_a);
            mag_b <= cap_mag_b;
            neg   <= cap_neg;
            acc   <= '0;
            step  <= '0;
            if (skip_on_accept) out_r <= '0;
          end
        end
        BUSY: begin
          acc   <= sum;
          mag_a <= mag_a << DIGIT_BITS;
          mag_b <= mag_b_rem;
          step  <= step + STEP_W'(1);
          // The final digit's partial product is folded in here rather than a cycle later.
          if (finish_busy) out_r <= neg ? -sum : sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench: 13x4/2 instance plus 8x8 instances with digit widths 1, 3, 8.
module tb_seq_multiplier;

  localparam int unsigned WA = 13;
  localparam int unsigned WB = 4;
  localparam int unsigned DB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  seq_multiplier_if #(.WIDTH_A(WA), .WIDTH_B(WB)) m_if ();
  seq_multiplier_if #(.WIDTH_A(8),  .WIDTH_B(8))  s1_if ();
  seq_multiplier_if #(.WIDTH_A(8),  .WIDTH_B(8))  s3_if ();
  seq_multiplier_if #(.WIDTH_A(8),  .WIDTH_B(8))  s8_if ();

  seq_multiplier #(.WIDTH_A(WA), .WIDTH_B(WB), .DIGIT_BITS(DB)) dut (
    .clk(clk), .rst(rst), .bus(m_if.slave));
  seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8), .DIGIT_BITS(1)) dut_s1 (
    .clk(clk), .rst(rst), .bus(s1_if.slave));
  seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8), .DIGIT_BITS(3)) dut_s3 (
    .clk(clk), .rst(rst), .bus(s3_if.slave));
  seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8), .DIGIT_BITS(8)) dut_s8 (
    .clk(clk), .rst(rst), .bus(s8_if.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int w, input bit sgn);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (sgn && ((m >> (w - 1)) & 1) == 1) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic logic [63:0] ref_product(input longint a, input longint b,
                                              input int wa, input int wb, input bit sgn);
    longint p;
    p = sext(a, wa, sgn) * sext(b, wb, sgn);
    return 64'(p & ((longint'(1) << (wa + wb)) - 1));
  endfunction

  function automatic int ref_latency(input longint b, input int wb, input int d, input bit sgn);
    longint m;
    int k;
    m = sext(b, wb, sgn);
    if (m < 0) m = -m;
    k = (wb + d - 1) / d;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    k = 0;
    while (m != 0) begin
      m = m >> d;
      k++;
    end
`endif
    return k;
  endfunction

  task automatic run_txn(input logic [WA-1:0] a, input logic [WB-1:0] b, input bit sgn,
                         input int stall, input string tag);
    int lat;
    int guard;
    guard = 0;
    while (!m_if.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq({tag, ".rdy"}, 64'(m_if.in_ready), 64'd1);
    m_if.in_a      = a;
    m_if.in_b      = b;
    m_if.in_signed = sgn;
    m_if.in_valid  = 1'b1;
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    lat = 0;
    while (!m_if.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".lat"}, 64'(lat), 64'(ref_latency(longint'(b), WB, DB, sgn)));
    check_eq({tag, ".out"}, 64'(m_if.out), ref_product(longint'(a), longint'(b), WA, WB, sgn));
    repeat (stall) begin
      @(posedge clk); #1;
    end
    m_if.out_ready = 1'b1;
    @(posedge clk); #1;
    m_if.out_ready = 1'b0;
    check_eq({tag, ".drop"}, 64'(m_if.out_valid), 64'd0);
  endtask

  task automatic sweep_txn(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int l1, l3, l8;
    logic [63:0] expv;
    check_eq("sw.rdy", 64'({s1_if.in_ready, s3_if.in_ready, s8_if.in_ready}), 64'd7);
    s1_if.in_a = a; s1_if.in_b = b; s1_if.in_signed = sgn; s1_if.in_valid = 1'b1;
    s3_if.in_a = a; s3_if.in_b = b; s3_if.in_signed = sgn; s3_if.in_valid = 1'b1;
    s8_if.in_a = a; s8_if.in_b = b; s8_if.in_signed = sgn; s8_if.in_valid = 1'b1;
    @(posedge clk); #1;
    s1_if.in_valid = 1'b0; s3_if.in_valid = 1'b0; s8_if.in_valid = 1'b0;
    l1 = -1; l3 = -1; l8 = -1;
    for (int c = 0; c <= 40; c++) begin
      if (l1 < 0 && s1_if.out_valid) l1 = c;
      if (l3 < 0 && s3_if.out_valid) l3 = c;
      if (l8 < 0 && s8_if.out_valid) l8 = c;
      if (l1 >= 0 && l3 >= 0 && l8 >= 0) break;
      @(posedge clk); #1;
    end
    expv = ref_product(longint'(a), longint'(b), 8, 8, sgn);
    check_eq("sw1.lat", 64'(l1), 64'(ref_latency(longint'(b), 8, 1, sgn)));
    check_eq("sw3.lat", 64'(l3), 64'(ref_latency(longint'(b), 8, 3, sgn)));
    check_eq("sw8.lat", 64'(l8), 64'(ref_latency(longint'(b), 8, 8, sgn)));
    check_eq("sw1.out", 64'(s1_if.out), expv);
    check_eq("sw3.out", 64'(s3_if.out), expv);
    check_eq("sw8.out", 64'(s8_if.out), expv);
    s1_if.out_ready = 1'b1; s3_if.out_ready = 1'b1; s8_if.out_ready = 1'b1;
    @(posedge clk); #1;
    s1_if.out_ready = 1'b0; s3_if.out_ready = 1'b0; s8_if.out_ready = 1'b0;
    check_eq("sw.drop", 64'({s1_if.out_valid, s3_if.out_valid, s8_if.out_valid}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    logic [63:0]   held;
    int            lat;
    logic [7:0]    sa, sb;

    m_if.in_valid = 1'b0;  m_if.in_signed = 1'b0;  m_if.in_a = '0;  m_if.in_b = '0;  m_if.out_ready = 1'b0;
    s1_if.in_valid = 1'b0; s1_if.in_signed = 1'b0; s1_if.in_a = '0; s1_if.in_b = '0; s1_if.out_ready = 1'b0;
    s3_if.in_valid = 1'b0; s3_if.in_signed = 1'b0; s3_if.in_a = '0; s3_if.in_b = '0; s3_if.out_ready = 1'b0;
    s8_if.in_valid = 1'b0; s8_if.in_signed = 1'b0; s8_if.in_a = '0; s8_if.in_b = '0; s8_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.in_ready", 64'(m_if.in_ready), 64'd0);
    check_eq("rst.out_valid", 64'(m_if.out_valid), 64'd0);
    check_eq("rst.out", 64'(m_if.out), 64'd0);
    check_eq("rst.busy", 64'(m_if.busy), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rel.in_ready", 64'(m_if.in_ready), 64'd1);

    run_txn(13'd8191, 4'd15, 1'b0, 0, "u_max");
    check_eq("u_max.const", 64'(m_if.out), 64'h1DFF1);
    run_txn(13'h1000, 4'h8, 1'b1, 1, "s_minmin");
    check_eq("s_minmin.const", 64'(m_if.out), 64'h08000);
    run_txn(13'h1FFD, 4'd5, 1'b1, 0, "s_neg");
    check_eq("s_neg.const", 64'(m_if.out), 64'h1FFF1);
    run_txn(13'd1234, 4'd0, 1'b0, 0, "b_zero");
    check_eq("b_zero.const", 64'(m_if.out), 64'd0);
    run_txn(13'd7, 4'd1, 1'b0, 0, "b_one");
    check_eq("b_one.const", 64'(m_if.out), 64'd7);

    // Back-pressure: product must hold while a second request waits at the input.
    m_if.in_a = 13'd100; m_if.in_b = 4'd3; m_if.in_signed = 1'b0; m_if.in_valid = 1'b1;
    @(posedge clk); #1;
    m_if.in_a = 13'd5; m_if.in_b = 4'd6;
    lat = 0;
    while (!m_if.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("stall.first", 64'(m_if.out), 64'd300);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("stall.out", 64'(m_if.out), 64'd300);
      check_eq("stall.valid", 64'(m_if.out_valid), 64'd1);
      check_eq("stall.in_ready", 64'(m_if.in_ready), 64'd0);
      check_eq("stall.busy", 64'(m_if.busy), 64'd1);
    end
    m_if.out_ready = 1'b1;
    @(posedge clk); #1;
    m_if.out_ready = 1'b0;
    check_eq("stall.rel_valid", 64'(m_if.out_valid), 64'd0);
    check_eq("stall.rel_ready", 64'(m_if.in_ready), 64'd1);
    check_eq("stall.rel_busy", 64'(m_if.busy), 64'd0);
    check_eq("stall.rel_hold", 64'(m_if.out), 64'd300);
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    lat = 0;
    while (!m_if.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("stall.second", 64'(m_if.out), 64'd30);
    m_if.out_ready = 1'b1;
    @(posedge clk); #1;
    m_if.out_ready = 1'b0;

    // Reset during the first BUSY cycle discards the operation.
    m_if.in_a = 13'd50; m_if.in_b = 4'd9; m_if.in_signed = 1'b0; m_if.in_valid = 1'b1;
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    check_eq("mid.busy", 64'(m_if.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid.out_valid", 64'(m_if.out_valid), 64'd0);
    check_eq("mid.out", 64'(m_if.out), 64'd0);
    check_eq("mid.busy0", 64'(m_if.busy), 64'd0);
    check_eq("mid.in_ready", 64'(m_if.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("mid.rel_ready", 64'(m_if.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("mid.no_out", 64'(m_if.out_valid), 64'd0);
    end
    run_txn(13'd3, 4'd3, 1'b0, 0, "post_rst");
    check_eq("post_rst.const", 64'(m_if.out), 64'd9);

    for (int i = 0; i < 150; i++) begin
      ra = WA'($urandom);
      rb = WB'($urandom);
      run_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    sweep_txn(8'h80, 8'h80, 1'b1);
    sweep_txn(8'hFF, 8'hFF, 1'b0);
    sweep_txn(8'hFF, 8'hFF, 1'b1);
    sweep_txn(8'h7F, 8'h80, 1'b1);
    sweep_txn(8'h00, 8'hFF, 1'b0);
    sweep_txn(8'h5A, 8'h00, 1'b1);
    sweep_txn(8'h01, 8'h01, 1'b1);
    for (int i = 0; i < 300; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      sweep_txn(sa, sb, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
